key_debounce_array: RTL and testbench

//  N-channel key debouncer, the parametrised successor to the single-key detector.

---
 rtl/key_pkg.sv | 13 +
 rtl/key_debounce_array_if.sv | 29 ++
 rtl/key_debounce_ch.sv | 136 +++++++++++++
 rtl/key_debounce_array.sv | 44 ++++
 tb/tb_key_debounce_array.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key debounce channels: per-channel FSM state encoding.
package key_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } key_state_t;

endpackage

// File: rtl/key_debounce_array_if.sv
// Key pins in, debounced per-channel events out.
// key_repeat is only driven active when the design is built with KEY_REPEAT_EN.
interface key_debounce_array_if #(
  parameter int unsigned N_KEYS = 4
);

  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] press_down;
  logic [N_KEYS-1:0] press_up;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output key_in,
    input  press_down,
    input  press_up,
    input  key_level,
    input  key_repeat
  );

  modport slave (
    input  key_in,
    output press_down,
    output press_up,
    output key_level,
    output key_repeat
  );

endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: synchroniser, polarity normalisation, counter debounce FSM.
// Build with KEY_REPEAT_EN to add the hold-to-repeat pulse generator.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC  = 100000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic press_down,
  output logic press_up,
  output logic key_level,
  output logic key_repeat
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic            RELEASED = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYC < 2 || SYNC_STAGES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("key_debounce_ch: unsupported parameter set");
  end

  // Reset loads the released level so leaving reset never looks like an edge.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RELEASED}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_in};
    end
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ RELEASED;

  key_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      press_down <= 1'b0;
      press_up   <= 1'b0;
      key_level  <= 1'b0;
    end else begin
      press_down <= 1'b0;
      press_up   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pressed) begin
            state_q <= WAIT_DOWN;
            cnt_q   <= '0;
          end
        end
        WAIT_DOWN: begin
          if (!pressed) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= DOWN;
            press_down <= 1'b1;
            key_level  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DOWN: begin
          if (!pressed) begin
            state_q <= WAIT_UP;
            cnt_q   <= '0;
          end
        end
        WAIT_UP: begin
          if (pressed) begin
            state_q <= DOWN;
          end else if (cnt_q == CNT_LAST) begin
            state_q   <= IDLE;
            press_up  <= 1'b1;
            key_level <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_target;
  logic              rep_phase_q;

  // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
  assign hold_target = rep_phase_q ? HOLD_W'(REPEAT_PERIOD - 1) : HOLD_W'(REPEAT_DELAY - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q      <= '0;
      rep_phase_q <= 1'b0;
      key_repeat  <= 1'b0;
    end else begin
      key_repeat <= 1'b0;
      if (state_q == DOWN && pressed) begin
        if (hold_q == hold_target) begin
          hold_q      <= '0;
          rep_phase_q <= 1'b1;
          key_repeat  <= 1'b1;
        end else begin
          hold_q <= hold_q + HOLD_W'(1);
        end
      end else begin
        hold_q      <= '0;
        rep_phase_q <= 1'b0;
      end
    end
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N independent debounced key channels behind one interface.
// KEY_REPEAT_EN enables per-channel hold-to-repeat pulses; the port list is the same either way.
module key_debounce_array #(
  parameter int unsigned N_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYC  = 100000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW    = 1,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input logic                 clk,
  input logic                 rst,
  key_debounce_array_if.slave kif
);

  logic [N_KEYS-1:0] press_down;
  logic [N_KEYS-1:0] press_up;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_repeat;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .SYNC_STAGES  (SYNC_STAGES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_in    (kif.key_in[i]),
      .press_down(press_down[i]),
      .press_up  (press_up[i]),
      .key_level (key_level[i]),
      .key_repeat(key_repeat[i])
    );
  end

  assign kif.press_down = press_down;
  assign kif.press_up   = press_up;
  assign kif.key_level  = key_level;
  assign kif.key_repeat = key_repeat;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: stimulus table, timing sequences and random keys vs a run-length model.
module tb_key_debounce_array;

  localparam int NK = 4;
  localparam int DC = 8;
  localparam int SS = 2;
  localparam int AL = 1;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif
  localparam int   REP4 = REP_ON ? 4 : 0;
  localparam logic REL  = (AL != 0);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debounce_array_if #(.N_KEYS(NK)) kif ();

  key_debounce_array #(
    .N_KEYS(NK), .DEBOUNCE_CYC(DC), .SYNC_STAGES(SS), .ACTIVE_LOW(AL),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kif(kif)
  );

  // Reference model: delayed raw samples, accepted level, length of the run disagreeing with it.
  logic m_dl [NK][SS];
  logic m_level [NK];
  int   m_run [NK];
  int   m_hold [NK];
  logic [NK-1:0] e_pd, e_pu, e_lvl, e_rep;

  int checks = 0;
  int failures = 0;
  int cnt_pd [NK];
  int cnt_pu [NK];
  int cnt_rep;

  typedef struct packed {
    logic          rst;
    logic [NK-1:0] key;
    int            ncyc;
    logic [NK-1:0] lvl;
    logic [NK-1:0] pd;
    logic [NK-1:0] pu;
    int            rep;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [NK-1:0] k, input int n,
                              input logic [NK-1:0] l, input logic [NK-1:0] pd,
                              input logic [NK-1:0] pu, input int rep);
    vec_t v;
    v.rst = r; v.key = k; v.ncyc = n; v.lvl = l; v.pd = pd; v.pu = pu; v.rep = rep;
    tbl.push_back(v);
  endfunction

  function automatic void model_step(input logic r, input logic [NK-1:0] k);
    for (int c = 0; c < NK; c++) begin
      logic vis, p, in_down;
      e_pd[c] = 1'b0; e_pu[c] = 1'b0; e_rep[c] = 1'b0;
      if (r) begin
        for (int s = 0; s < SS; s++) m_dl[c][s] = REL;
        m_level[c] = 1'b0; m_run[c] = 0; m_hold[c] = 0;
      end else begin
        vis = m_dl[c][SS-1];
        for (int s = SS-1; s > 0; s--) m_dl[c][s] = m_dl[c][s-1];
        m_dl[c][0] = k[c];
        p = vis ^ REL;
        in_down = m_level[c] && (m_run[c] == 0);
        // A level is accepted once DC+1 consecutive samples disagree with it.
        if (p != m_level[c]) begin
          m_run[c]++;
          if (m_run[c] == DC + 1) begin
            m_level[c] = p;
            m_run[c] = 0;
            if (p) e_pd[c] = 1'b1; else e_pu[c] = 1'b1;
          end
        end else begin
          m_run[c] = 0;
        end
        if (REP_ON && in_down && p) begin
          m_hold[c]++;
          if (m_hold[c] >= RD && ((m_hold[c] - RD) % RP) == 0) e_rep[c] = 1'b1;
        end else begin
          m_hold[c] = 0;
        end
      end
      e_lvl[c] = m_level[c];
    end
  endfunction

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic [NK-1:0] k);
    rst = r;
    kif.key_in = k;
    @(posedge clk);
    model_step(r, k);
    @(negedge clk);
    check("model_press_down", kif.press_down, e_pd);
    check("model_press_up", kif.press_up, e_pu);
    check("model_key_level", kif.key_level, e_lvl);
    check("model_key_repeat", kif.key_repeat, e_rep);
    for (int c = 0; c < NK; c++) begin
      cnt_pd[c] += int'(kif.press_down[c]);
      cnt_pu[c] += int'(kif.press_up[c]);
      cnt_rep   += int'(kif.key_repeat[c]);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NK; c++) begin
      cnt_pd[c] = 0;
      cnt_pu[c] = 0;
    end
    cnt_rep = 0;
  endtask

  // Runs n cycles of one key pattern and returns the index of the first press_down on channel ch.
  task automatic press_timing(input logic [NK-1:0] k, input int n, input int ch,
                              output int first, output int width);
    first = -1;
    width = 0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b0, k);
      if (kif.press_down[ch] === 1'b1) begin
        if (first < 0) first = i;
        width++;
      end
    end
  endtask

  logic [NK-1:0] kr;
  logic [NK-1:0] pdv, puv, multi;
  int lim, first, width;

  initial begin
    rst = 1'b1;
    kif.key_in = '1;
    clear_counts();

    add(1'b1, 4'hF, 3,  4'h0, 4'h0, 4'h0, 0);
    add(1'b0, 4'hF, 5,  4'h0, 4'h0, 4'h0, 0);
    add(1'b0, 4'hE, 12, 4'h1, 4'h1, 4'h0, 0);
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h1, 0);
    add(1'b0, 4'hE, 5,  4'h0, 4'h0, 4'h0, 0);
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h0, 0);
    add(1'b0, 4'h6, 12, 4'h9, 4'h9, 4'h0, 0);
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h9, 0);
    add(1'b0, 4'hD, 12, 4'h2, 4'h2, 4'h0, 0);
    for (int b = 0; b < 3; b++) begin
      add(1'b0, 4'hF, 2, 4'h2, 4'h0, 4'h0, 0);
      add(1'b0, 4'hD, 2, 4'h2, 4'h0, 4'h0, 0);
    end
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h2, 0);
    add(1'b0, 4'hE, 6,  4'h0, 4'h0, 4'h0, 0);
    add(1'b1, 4'hE, 3,  4'h0, 4'h0, 4'h0, 0);
    add(1'b0, 4'hE, 12, 4'h1, 4'h1, 4'h0, 0);
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h1, 0);
    add(1'b0, 4'hE, 48, 4'h1, 4'h1, 4'h0, REP4);
    add(1'b0, 4'hF, 12, 4'h0, 4'h0, 4'h1, 0);

    foreach (tbl[i]) begin
      clear_counts();
      for (int n = 0; n < tbl[i].ncyc; n++) cycle(tbl[i].rst, tbl[i].key);
      for (int c = 0; c < NK; c++) begin
        pdv[c]   = (cnt_pd[c] != 0);
        puv[c]   = (cnt_pu[c] != 0);
        multi[c] = (cnt_pd[c] > 1) || (cnt_pu[c] > 1);
      end
      check($sformatf("row%0d_level", i), kif.key_level, tbl[i].lvl);
      check($sformatf("row%0d_press_down", i), pdv, tbl[i].pd);
      check($sformatf("row%0d_press_up", i), puv, tbl[i].pu);
      check($sformatf("row%0d_multi_pulse", i), multi, 4'h0);
      check_int($sformatf("row%0d_repeat_count", i), cnt_rep, tbl[i].rep);
    end

    // Press on channel 2 from idle: pulse set at edge S+D, one cycle wide.
    press_timing(4'b1011, 15, 2, first, width);
    check_int("t1_press_edge", first, SS + DC);
    check_int("t1_press_width", width, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'hF);

    // Key 3 held through reset: fresh press measured from reset release.
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0111);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0111);
    check("t5_outputs_in_reset", kif.press_down | kif.key_level, 4'h0);
    press_timing(4'b0111, 15, 3, first, width);
    check_int("t5_press_edge", first, SS + DC);
    check_int("t5_press_width", width, 1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 4'hF);

    kr = '1;
    for (int n = 0; n < 3000; n++) begin
      lim = (n < 1500) ? 11 : 39;
      for (int c = 0; c < NK; c++) begin
        if ($urandom_range(lim, 0) == 0) kr[c] = ~kr[c];
      end
      cycle(($urandom_range(399, 0) == 0), kr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
